// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end.
//   fetch_entry_t     : queued entry {pc, instr}
//   WADDR_W           : instruction RAM word-address width
//   HALT_WORD_DEFAULT : end-of-program marker word
//   log2c()           : ceiling log2, used for pointer/count widths
package fetch_pkg;

  localparam int unsigned WADDR_W = 30;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic int unsigned log2c(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the fetch front end's redirect, instruction-RAM and
// decode-side handshake signals.
//   master : the fetch_queue side (drives imem_req/imem_addr, out_*, halted)
//   slave  : the environment side (redirect source, RAM, decode)
// Optional macro FETCH_QUEUE_PERF_EN adds perf_fetches, perf_stall_cycles and
// perf_flushes counters driven by the master.
interface fetch_queue_if;
  import fetch_pkg::*;

  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               imem_req;
  logic [WADDR_W-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_instr;
  logic [31:0]        out_pc;
  logic [31:0]        out_pcplus4;
  logic               halted;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0]        perf_fetches;
  logic [31:0]        perf_stall_cycles;
  logic [31:0]        perf_flushes;

  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pcplus4,
           halted, perf_fetches, perf_stall_cycles, perf_flushes
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pcplus4,
           halted, perf_fetches, perf_stall_cycles, perf_flushes
  );
`else
  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pcplus4,
           halted
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pcplus4,
           halted
  );
`endif

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of fetch_entry_t with synchronous flush.
//   clk_i/rst_ni : clock, async active-low reset
//   flush_i      : clears pointers and count (wins over push/pop)
//   push_i/push_data_i : write at tail
//   pop_i        : remove head (ignored when empty)
//   head_o       : head entry (meaningful only when count_o != 0)
//   count_o      : number of stored entries, 0..DEPTH
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic [log2c(DEPTH):0]  count_o
);

  localparam int unsigned PW = log2c(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is the natural overflow.
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (PW+1)'(push_i) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end ahead of the IF/ID register.
// Owns the PC, issues word requests to a 1-cycle-latency instruction RAM,
// buffers {pc, word} in fetch_fifo and presents the head to decode with a
// valid/ready handshake. Redirects flush the queue and drop the in-flight
// response; a HALT_WORD response stops fetching until the next redirect.
//   CLK, RESET_N : clock, async active-low reset
//   bus          : fetch_queue_if.master (redirect, imem_*, out_*, halted)
// Optional macro FETCH_QUEUE_PERF_EN adds saturating perf counters.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic          CLK,
  input  logic          RESET_N,
  fetch_queue_if.master bus
);

  localparam int unsigned CW = log2c(DEPTH) + 1;

  logic [31:0]   pc_q, pc_d, tag_q, tag_d;
  logic          inflight_q, inflight_d, halted_q, halted_d;
  logic [CW-1:0] count;
  fetch_entry_t  head, push_entry;
  logic          valid, issue, push, pop;

  always_comb begin
    valid = (count != '0);
    // Slots are reserved at issue time so the response always has room.
    // RESET_N gating keeps imem_req low while reset is held.
    issue = RESET_N && !halted_q && !bus.redirect_valid &&
            ((count + CW'(inflight_q)) < CW'(DEPTH));
    // Responses arriving once halted belong to words past the end marker.
    push  = inflight_q && !halted_q && !bus.redirect_valid;
    pop   = valid && bus.out_ready && !bus.redirect_valid;
    push_entry = '{pc: tag_q, instr: bus.imem_rdata};

    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = issue;
    halted_d   = halted_q;
    if (bus.redirect_valid) begin
      pc_d     = bus.redirect_pc & 32'hFFFF_FFFC;
      halted_d = 1'b0;
    end else begin
      if (issue) begin
        pc_d  = pc_q + 32'd4;
        tag_d = pc_q;
      end
      if (push && (bus.imem_rdata == HALT_WORD)) halted_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      halted_q   <= halted_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (CLK),
    .rst_ni      (RESET_N),
    .flush_i     (bus.redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = pc_q[31:2];
  assign bus.out_valid   = valid;
  assign bus.out_instr   = valid ? head.instr : '0;
  assign bus.out_pc      = valid ? head.pc : '0;
  assign bus.out_pcplus4 = valid ? head.pc + 32'd4 : '0;
  assign bus.halted      = halted_q;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] fetches_q, stalls_q, flushes_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fetches_q <= '0;
      stalls_q  <= '0;
      flushes_q <= '0;
    end else begin
      if (push && (fetches_q != '1)) fetches_q <= fetches_q + 32'd1;
      if (valid && !bus.out_ready && (stalls_q != '1)) stalls_q <= stalls_q + 32'd1;
      if (bus.redirect_valid && (flushes_q != '1)) flushes_q <= flushes_q + 32'd1;
    end
  end

  assign bus.perf_fetches      = fetches_q;
  assign bus.perf_stall_cycles = stalls_q;
  assign bus.perf_flushes      = flushes_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic CLK = 1'b0;
  logic RESET_N;

  fetch_queue_if bus();

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000), .HALT_WORD(HALT)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [64];
  int tests = 0;
  int fails = 0;

  // Reference model: PC, one in-flight tag, and a queue of entries.
  logic [31:0]  m_pc, m_tag;
  bit           m_inflight, m_halted;
  fetch_entry_t m_q[$];
  logic [31:0]  m_fetches, m_stalls, m_flushes;

  // Instruction RAM emulation.
  bit          resp_pend;
  logic [29:0] resp_addr;

  // Stimulus for the next cycle and values sampled in the last cycle.
  logic        drv_ready, drv_redir;
  logic [31:0] drv_rpc;
  logic        s_req, s_valid, s_halted;
  logic [29:0] s_addr;
  logic [31:0] s_pc, s_instr, s_pc4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset;
    m_pc = 32'h0; m_tag = 32'h0; m_inflight = 0; m_halted = 0;
    m_q.delete();
    m_fetches = 0; m_stalls = 0; m_flushes = 0;
    resp_pend = 0; resp_addr = '0;
  endtask

  task automatic do_reset;
    @(negedge CLK);
    RESET_N = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready = drv_ready;
    model_reset();
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_out_pc", bus.out_pc, 0);
    chk("rst_out_instr", bus.out_instr, 0);
    @(posedge CLK);
    #2 RESET_N = 1'b1;
  endtask

  task automatic run_cycle;
    bit          exp_req, exp_valid, push;
    logic [31:0] rd;
    @(negedge CLK);
    bus.out_ready      = drv_ready;
    bus.redirect_valid = drv_redir;
    bus.redirect_pc    = drv_rpc;
    rd = resp_pend ? mem[resp_addr[5:0]] : $urandom;
    bus.imem_rdata = rd;
    #1;
    exp_req   = !m_halted && !drv_redir && ((m_q.size() + int'(m_inflight)) < 4);
    exp_valid = (m_q.size() > 0);
    chk("imem_req", bus.imem_req, exp_req);
    if (exp_req) chk("imem_addr", bus.imem_addr, {2'b00, m_pc[31:2]});
    chk("out_valid", bus.out_valid, exp_valid);
    chk("halted", bus.halted, m_halted);
    if (exp_valid) begin
      chk("out_pc", bus.out_pc, m_q[0].pc);
      chk("out_instr", bus.out_instr, m_q[0].instr);
      chk("out_pcplus4", bus.out_pcplus4, m_q[0].pc + 32'd4);
    end
`ifdef FETCH_QUEUE_PERF_EN
    chk("perf_fetches", bus.perf_fetches, m_fetches);
    chk("perf_stall_cycles", bus.perf_stall_cycles, m_stalls);
    chk("perf_flushes", bus.perf_flushes, m_flushes);
`endif
    s_req = bus.imem_req; s_addr = bus.imem_addr; s_valid = bus.out_valid;
    s_halted = bus.halted; s_pc = bus.out_pc; s_instr = bus.out_instr;
    s_pc4 = bus.out_pcplus4;
    resp_pend = bus.imem_req;
    resp_addr = bus.imem_addr;

    // Advance the model across the coming edge.
    if (exp_valid && !drv_ready) m_stalls = sat_inc(m_stalls);
    if (drv_redir) begin
      m_flushes  = sat_inc(m_flushes);
      m_q.delete();
      m_inflight = 0;
      m_halted   = 0;
      m_pc       = {drv_rpc[31:2], 2'b00};
    end else begin
      push = m_inflight && !m_halted;
      if (exp_valid && drv_ready) void'(m_q.pop_front());
      if (push) begin
        m_fetches = sat_inc(m_fetches);
        m_q.push_back(fetch_entry_t'{pc: m_tag, instr: rd});
        if (rd == HALT) m_halted = 1;
      end
      m_inflight = exp_req;
      if (exp_req) begin
        m_tag = m_pc;
        m_pc  = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    int nreq, n2;
    logic [31:0] got[$];

    RESET_N = 1'b0;
    drv_ready = 1'b1; drv_redir = 1'b0; drv_rpc = 32'h0;
    bus.out_ready = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    bus.imem_rdata = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom & 32'h7FFF_FFFF;

    // Basic stream and 2-cycle latency.
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;
    drv_ready = 1'b1;
    do_reset();
    run_cycle();
    chk("t1_req0", s_req, 1);
    chk("t1_addr0", s_addr, 0);
    chk("t1_valid0", s_valid, 0);
    run_cycle();
    chk("t1_addr1", s_addr, 1);
    chk("t1_valid1", s_valid, 0);
    run_cycle();
    chk("t1_addr2", s_addr, 2);
    chk("t1_valid2", s_valid, 1);
    chk("t1_pc2", s_pc, 32'h0);
    chk("t1_instr2", s_instr, 32'h2008_0005);
    chk("t1_pc4_2", s_pc4, 32'h4);
    run_cycle();
    chk("t1_pc3", s_pc, 32'h4);
    chk("t1_instr3", s_instr, 32'h2009_0003);

    // Full queue backpressure.
    drv_ready = 1'b0;
    do_reset();
    nreq = 0;
    for (int i = 0; i < 8; i++) begin
      run_cycle();
      if (s_req) begin
        chk("t2_addr", s_addr, nreq);
        nreq++;
      end
    end
    chk("t2_nreq", nreq, 4);
    drv_ready = 1'b1;
    run_cycle();
    n2 = int'(s_req);
    drv_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      if (s_req) begin
        chk("t2_addr_after_pop", s_addr, 4);
        n2++;
      end
    end
    chk("t2_nreq_after_pop", n2, 1);

    // Redirect with a response in flight.
    drv_ready = 1'b1;
    do_reset();
    repeat (6) run_cycle();
    drv_redir = 1'b1; drv_rpc = 32'h0000_0043;
    run_cycle();
    chk("t3_req_in_redirect", s_req, 0);
    drv_redir = 1'b0;
    run_cycle();
    chk("t3_valid_after", s_valid, 0);
    chk("t3_req_after", s_req, 1);
    chk("t3_addr_after", s_addr, 16);
    run_cycle();
    chk("t3_valid_c1", s_valid, 0);
    run_cycle();
    chk("t3_valid_c2", s_valid, 1);
    chk("t3_pc_c2", s_pc, 32'h40);
    chk("t3_instr_c2", s_instr, mem[16]);

    // Halt word at address 3, then redirect out of halt.
    mem[3] = HALT;
    drv_ready = 1'b1;
    do_reset();
    got.delete();
    for (int i = 0; i < 10; i++) begin
      run_cycle();
      if (s_valid) got.push_back(s_pc);
    end
    chk("t4_ndelivered", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++) chk("t4_pc", got[i], 32'(i * 4));
    chk("t4_halted", s_halted, 1);
    chk("t4_no_req", s_req, 0);
    drv_redir = 1'b1; drv_rpc = 32'h20;
    run_cycle();
    drv_redir = 1'b0;
    run_cycle();
    chk("t4_halted_cleared", s_halted, 0);
    chk("t4_resume_req", s_req, 1);
    chk("t4_resume_addr", s_addr, 8);
    mem[3] = 32'h1234_5678;

    // Reset while entries are queued.
    drv_ready = 1'b0;
    do_reset();
    repeat (4) run_cycle();
    chk("t5_valid_before_reset", s_valid, 1);
    do_reset();
    run_cycle();
    chk("t5_restart_req", s_req, 1);
    chk("t5_restart_addr", s_addr, 0);

    // Randomized traffic with halts, redirects and PC wrap.
    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(0, 11) == 0) ? HALT : ($urandom & 32'h7FFF_FFFF);
    drv_ready = 1'b1; drv_redir = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drv_ready = ($urandom_range(0, 9) < 7);
      drv_redir = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) drv_rpc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      else drv_rpc = $urandom_range(0, 255);
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
